// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder cell, purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, start/done handshake.
// Handshake: start is sampled only in IDLE or DONE; done pulses one cycle and sum/cout hold until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_e           state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] part_nxt;

    fa_cell u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    // New result bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign part_nxt = (part_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        part_d  = part_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                part_d  = part_nxt;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = part_nxt;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and an exhaustive sweep at WIDTH=2.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    state_e     state8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    state_e     state2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_o(state8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .state_o(state2)
    );

    // Drives one add on the 8-bit DUT and returns edges-to-done (accepting edge counts as 1), or -1.
    task automatic run_add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                            output int lat, output int busy_n);
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; busy_n = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic run_add2(input logic [1:0] ta, input logic [1:0] tb, input logic tc,
                            output int lat);
        @(negedge clk);
        a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done2) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 || state8 !== IDLE) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b state=%0d, want 0 0 00 0 0",
                     busy8, done8, sum8, cout8, state8);
        end
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || sum2 !== 2'b00 || cout2 !== 1'b0) begin
            failures++;
            $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b, want 0 0 0 0",
                     busy2, done2, sum2, cout2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bn;
        run_add8(8'h35, 8'h4A, 1'b0, lat, bn);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, want 9", lat);
        end
        checks++;
        if (bn !== 8) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
        end
        checks++;
        if (sum8 !== 8'h7F || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got cout=%b sum=%h, want 0 7f", cout8, sum8);
        end
    endtask

    task automatic test_carry_ripple();
        int lat, bn;
        run_add8(8'hFF, 8'h01, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            failures++;
            $display("FAIL ripple_ff_01: lat=%0d cout=%b sum=%h, want 9 1 00", lat, cout8, sum8);
        end
        run_add8(8'hFF, 8'hFF, 1'b1, lat, bn);
        checks++;
        if (lat !== 9 || sum8 !== 8'hFF || cout8 !== 1'b1) begin
            failures++;
            $display("FAIL ripple_ff_ff_c1: lat=%0d cout=%b sum=%h, want 9 1 ff", lat, cout8, sum8);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extra_done;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        lat++;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!done8 || lat !== 9) begin
            failures++;
            $display("FAIL busy_ignore_latency: got %0d edges done=%b, want 9 1", lat, done8);
        end
        checks++;
        if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_result: got cout=%b sum=%h, want 0 46", cout8, sum8);
        end
        extra_done = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8 || busy8) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            failures++;
            $display("FAIL busy_ignore_no_second: got %0d busy/done cycles, want 0", extra_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn, held_bad;
        run_add8(8'h11, 8'h22, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || sum8 !== 8'h33) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d sum=%h, want 9 33", lat, sum8);
        end
        // Still in the DONE cycle: request the next add immediately.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_bubble: busy=%b after DONE-cycle start, want 1", busy8);
        end
        lat = 1; held_bad = 0;
        while (!done8 && lat < 40) begin
            if (sum8 !== 8'h33) held_bad++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (held_bad !== 0) begin
            failures++;
            $display("FAIL b2b_sum_held: %0d cycles with sum changed, want 0", held_bad);
        end
        checks++;
        if (!done8 || lat !== 9 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d cout=%b sum=%h, want 9 0 30", lat, cout8, sum8);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bn, seen;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                     busy8, done8, sum8, cout8);
        end
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_done: %0d busy/done cycles, want 0", seen);
        end
        run_add8(8'h80, 8'h80, 1'b0, lat, bn);
        checks++;
        if (lat !== 9 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_fresh: lat=%0d cout=%b sum=%h, want 9 1 00", lat, cout8, sum8);
        end
    endtask

    task automatic test_exhaustive_w2();
        int lat;
        logic [1:0] ta, tb;
        logic       tc;
        logic [2:0] exp;
        for (int i = 0; i < 32; i++) begin
            ta  = i[1:0];
            tb  = i[3:2];
            tc  = i[4];
            exp = {1'b0, ta} + {1'b0, tb} + {2'b00, tc};
            run_add2(ta, tb, tc, lat);
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL w2_latency a=%0d b=%0d cin=%0d: got %0d edges, want 3", ta, tb, tc, lat);
            end
            checks++;
            if ({cout2, sum2} !== exp) begin
                failures++;
                $display("FAIL w2_result a=%0d b=%0d cin=%0d: got %0d, want %0d",
                         ta, tb, tc, {cout2, sum2}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive_w2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
